// File: rtl/univ_ff_pkg.sv
// Shared definitions for the universal flip-flop bank.
// Contents:
//   ff_mode_t  2-bit run-time flip-flop mode (D, T, JK, SR)
//   ff_next    next-state function for one bit, returns {q_next, illegal}
package univ_ff_pkg;

    typedef enum logic [1:0] {
        MODE_D  = 2'b00,
        MODE_T  = 2'b01,
        MODE_JK = 2'b10,
        MODE_SR = 2'b11
    } ff_mode_t;

    // Next-state evaluation for a single bit.
    // An illegal SR pair (S=R=1) never produces x: it either holds q or clears it,
    // depending on sr_hold, and raises the illegal flag.
    function automatic logic [1:0] ff_next(
        input ff_mode_t mode,
        input logic     q,
        input logic     a,
        input logic     b,
        input logic     sr_hold
    );
        logic nxt;
        logic ill;
        nxt = q;
        ill = 1'b0;
        case (mode)
            MODE_D:  nxt = a;
            MODE_T:  nxt = q ^ a;
            MODE_JK: begin
                case ({a, b})
                    2'b00:   nxt = q;
                    2'b01:   nxt = 1'b0;
                    2'b10:   nxt = 1'b1;
                    2'b11:   nxt = ~q;
                    default: nxt = q;
                endcase
            end
            MODE_SR: begin
                case ({a, b})
                    2'b00:   nxt = q;
                    2'b01:   nxt = 1'b0;
                    2'b10:   nxt = 1'b1;
                    2'b11: begin
                        ill = 1'b1;
                        nxt = sr_hold ? q : 1'b0;
                    end
                    default: nxt = q;
                endcase
            end
            default: nxt = q;
        endcase
        return {nxt, ill};
    endfunction

endpackage

// File: rtl/univ_ff_cell.sv
// One bit of the universal flip-flop bank.
// Ports:
//   clk, rst         clock and synchronous active-high reset
//   mode             current mode (from the bank's mode register)
//   en               apply the flip-flop update this cycle
//   load, load_val   synchronous load of q (wins over en)
//   a, b             D/T/J/S and K/R inputs
//   err_clr          clear the sticky error flag
//   q                registered state
//   chg              1 when q changed on the last edge
//   err              sticky illegal-SR flag
module univ_ff_cell
    import univ_ff_pkg::*;
#(
    parameter logic RST_VAL = 1'b0,
    parameter logic SR_HOLD = 1'b1
) (
    input  logic     clk,
    input  logic     rst,
    input  ff_mode_t mode,
    input  logic     en,
    input  logic     load,
    input  logic     load_val,
    input  logic     a,
    input  logic     b,
    input  logic     err_clr,
    output logic     q,
    output logic     chg,
    output logic     err
);

    logic       q_r;
    logic       chg_r;
    logic       err_r;
    logic [1:0] ff_res_s;
    logic       q_next_s;
    logic       err_next_s;

    // Next-state selection: load beats en; a load never records an error.
    // A fresh illegal bit is set even when err_clr clears the old flag.
    always_comb begin
        ff_res_s   = ff_next(mode, q_r, a, b, SR_HOLD);
        q_next_s   = q_r;
        err_next_s = err_r & ~err_clr;
        if (load) begin
            q_next_s   = load_val;
            err_next_s = err_r & ~err_clr;
        end else if (en) begin
            q_next_s   = ff_res_s[1];
            err_next_s = ff_res_s[0] | (err_r & ~err_clr);
        end else begin
            q_next_s   = q_r;
            err_next_s = err_r & ~err_clr;
        end
    end

    // State registers; chg is 0 on hold cycles because q_next equals q.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r   <= RST_VAL;
            chg_r <= 1'b0;
            err_r <= 1'b0;
        end else begin
            q_r   <= q_next_s;
            chg_r <= q_r ^ q_next_s;
            err_r <= err_next_s;
        end
    end

    assign q   = q_r;
    assign chg = chg_r;
    assign err = err_r;

endmodule

// File: rtl/univ_ff_bank.sv
// WIDTH-bit bank of universal flip-flops sharing one clock and one mode register.
// Each bit acts as a D, T, JK or SR flip-flop chosen at run time.
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   mode_in      mode to load (00 D, 01 T, 10 JK, 11 SR)
//   mode_ld      load mode_in; takes effect from the following edge
//   en           apply flip-flop update
//   a, b         per-bit inputs (b ignored in D and T modes)
//   load         parallel load of q with load_val
//   err_clr      clear err_mask
//   mode         current mode register
//   q, q_bar     state and its complement (q_bar combinational)
//   chg          bits that changed on the last edge
//   err_mask     sticky per-bit illegal-SR flags
//   err          OR of err_mask (combinational)
module univ_ff_bank
    import univ_ff_pkg::*;
#(
    parameter int               WIDTH           = 8,
    parameter logic [WIDTH-1:0] RST_VAL         = '0,
    parameter ff_mode_t         RST_MODE        = MODE_T,
    parameter int               SR_ILLEGAL_HOLD = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode_in,
    input  logic             mode_ld,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             err_clr,
    output logic [1:0]       mode,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic [WIDTH-1:0] chg,
    output logic [WIDTH-1:0] err_mask,
    output logic             err
);

    localparam logic SR_HOLD = (SR_ILLEGAL_HOLD != 0);

    ff_mode_t mode_r;

    // Mode register: cells see the old value during the cycle mode_ld is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_r <= RST_MODE;
        end else if (mode_ld) begin
            mode_r <= ff_mode_t'(mode_in);
        end else begin
            mode_r <= mode_r;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        univ_ff_cell #(
            .RST_VAL (RST_VAL[i]),
            .SR_HOLD (SR_HOLD)
        ) u_cell (
            .clk      (clk),
            .rst      (rst),
            .mode     (mode_r),
            .en       (en),
            .load     (load),
            .load_val (load_val[i]),
            .a        (a[i]),
            .b        (b[i]),
            .err_clr  (err_clr),
            .q        (q[i]),
            .chg      (chg[i]),
            .err      (err_mask[i])
        );
    end

    assign mode  = mode_r;
    assign q_bar = ~q;
    assign err   = |err_mask;

endmodule

// File: tb/tb_univ_ff_bank.sv
// Directed testbench for univ_ff_bank (WIDTH=8, RST_VAL=0, RST_MODE=T, SR hold).
module tb_univ_ff_bank;

    logic       clk;
    logic       rst;
    logic [1:0] mode_in;
    logic       mode_ld;
    logic       en;
    logic [7:0] a;
    logic [7:0] b;
    logic       load;
    logic [7:0] load_val;
    logic       err_clr;
    logic [1:0] mode;
    logic [7:0] q;
    logic [7:0] q_bar;
    logic [7:0] chg;
    logic [7:0] err_mask;
    logic       err;

    int n_tests;
    int n_fail;

    univ_ff_bank dut (
        .clk      (clk),
        .rst      (rst),
        .mode_in  (mode_in),
        .mode_ld  (mode_ld),
        .en       (en),
        .a        (a),
        .b        (b),
        .load     (load),
        .load_val (load_val),
        .err_clr  (err_clr),
        .mode     (mode),
        .q        (q),
        .q_bar    (q_bar),
        .chg      (chg),
        .err_mask (err_mask),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock edge, then settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; mode_ld = 1'b0; en = 1'b0; load = 1'b0; err_clr = 1'b0;
        a = 8'h00; b = 8'h00; load_val = 8'h00; mode_in = 2'b00;
    endtask

    // Load q and mode together in one cycle.
    task automatic load_q_mode(input logic [7:0] v, input logic [1:0] m);
        idle();
        load = 1'b1; load_val = v; mode_ld = 1'b1; mode_in = m;
        tick();
        idle();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        idle();

        // 1. Reset overrides everything.
        rst = 1'b1; a = 8'hFF; b = 8'hFF; en = 1'b1; load = 1'b1; load_val = 8'h5A;
        mode_ld = 1'b1; mode_in = 2'b11;
        tick();
        tick();
        check("rst_q", {24'd0, q}, 32'h00);
        check("rst_qbar", {24'd0, q_bar}, 32'hFF);
        check("rst_chg", {24'd0, chg}, 32'h00);
        check("rst_err_mask", {24'd0, err_mask}, 32'h00);
        check("rst_err", {31'd0, err}, 32'h0);
        check("rst_mode", {30'd0, mode}, 32'h1);

        // 2. T mode toggling.
        idle();
        en = 1'b1; a = 8'h0F;
        tick();
        check("t1_q", {24'd0, q}, 32'h0F);
        check("t1_chg", {24'd0, chg}, 32'h0F);
        tick();
        check("t2_q", {24'd0, q}, 32'h00);
        check("t2_chg", {24'd0, chg}, 32'h0F);
        tick();
        check("t3_q", {24'd0, q}, 32'h0F);
        check("t3_chg", {24'd0, chg}, 32'h0F);

        // Hold: en=0 keeps q and clears chg.
        idle();
        a = 8'hFF;
        tick();
        check("hold_q", {24'd0, q}, 32'h0F);
        check("hold_chg", {24'd0, chg}, 32'h00);

        // 3. Load A5 with JK, then JK update.
        load_q_mode(8'hA5, 2'b10);
        check("ld_q", {24'd0, q}, 32'hA5);
        check("ld_chg", {24'd0, chg}, 32'hAA);
        check("ld_mode", {30'd0, mode}, 32'h2);
        en = 1'b1; a = 8'hF0; b = 8'h3C;
        tick();
        check("jk_q", {24'd0, q}, 32'hD1);
        check("jk_chg", {24'd0, chg}, 32'h74);
        check("jk_err", {31'd0, err}, 32'h0);

        // Load wins over en and records no error even with illegal SR inputs.
        load_q_mode(8'h00, 2'b11);
        load = 1'b1; load_val = 8'h33; en = 1'b1; a = 8'hFF; b = 8'hFF;
        tick();
        check("ldpri_q", {24'd0, q}, 32'h33);
        check("ldpri_err", {24'd0, err_mask}, 32'h00);

        // 4. SR mode with an illegal bit.
        load_q_mode(8'h00, 2'b11);
        en = 1'b1; a = 8'h81; b = 8'h01;
        tick();
        check("sr_q", {24'd0, q}, 32'h80);
        check("sr_err_mask", {24'd0, err_mask}, 32'h01);
        check("sr_err", {31'd0, err}, 32'h1);
        err_clr = 1'b1;
        tick();
        check("sr_clr_new_q", {24'd0, q}, 32'h80);
        check("sr_clr_new_mask", {24'd0, err_mask}, 32'h01);
        en = 1'b0;
        tick();
        check("sr_clr_mask", {24'd0, err_mask}, 32'h00);
        check("sr_clr_err", {31'd0, err}, 32'h0);
        // err_clr with a different new illegal bit: only the new one survives.
        err_clr = 1'b0; en = 1'b1; a = 8'h02; b = 8'h02;
        tick();
        err_clr = 1'b1; a = 8'h40; b = 8'h41;
        tick();
        check("sr_swap_mask", {24'd0, err_mask}, 32'h40);
        check("sr_swap_q", {24'd0, q}, 32'h80);
        // SR clear of bit 7.
        err_clr = 1'b0; a = 8'h00; b = 8'h80;
        tick();
        check("sr_reset_q", {24'd0, q}, 32'h00);
        check("sr_reset_chg", {24'd0, chg}, 32'h80);

        // 5. Mode change coincident with en uses the old (T) mode.
        load_q_mode(8'h00, 2'b01);
        en = 1'b1; a = 8'h3C; mode_ld = 1'b1; mode_in = 2'b00;
        tick();
        check("mchg_q", {24'd0, q}, 32'h3C);
        check("mchg_mode", {30'd0, mode}, 32'h0);
        mode_ld = 1'b0; a = 8'h00;
        tick();
        check("mchg_d_q", {24'd0, q}, 32'h00);
        check("mchg_d_chg", {24'd0, chg}, 32'h3C);

        // 6. Reset in the middle of T toggling.
        load_q_mode(8'h00, 2'b01);
        en = 1'b1; a = 8'hFF;
        tick();
        check("mid_t_q", {24'd0, q}, 32'hFF);
        rst = 1'b1; load = 1'b1; load_val = 8'hFF; mode_ld = 1'b1; mode_in = 2'b10;
        tick();
        check("mid_rst_q", {24'd0, q}, 32'h00);
        check("mid_rst_chg", {24'd0, chg}, 32'h00);
        check("mid_rst_mode", {30'd0, mode}, 32'h1);
        rst = 1'b0; load = 1'b0; mode_ld = 1'b0;
        tick();
        check("resume_q", {24'd0, q}, 32'hFF);
        check("resume_chg", {24'd0, chg}, 32'hFF);
        check("resume_qbar", {24'd0, q_bar}, 32'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
